// File: rtl/block_assembler_pkg.sv
// Shared AES types for the block assembler: word/state types, block geometry, FSM states.
package block_assembler_pkg;

  localparam int WORD_W  = 32;
  localparam int WORDS   = 4;
  localparam int STATE_W = 128;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [STATE_W-1:0] aes_state_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/block_assembler.sv
// Packs 32-bit words into 128-bit AES state blocks (word 0 in the MSW) behind a one-deep output slot.
// Optional BLOCK_PAD_EN: in_last closes a block early with zero-filled trailing words.
module block_assembler #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  output logic [WORD_W*WORDS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);
  import block_assembler_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(WORDS - 1);

  fsm_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  aes_state_t asm_q, asm_d;
  aes_state_t out_q, out_d;
  logic       out_valid_q, out_valid_d;
  aes_state_t blk;
  logic       accept, drain, slot_free, done;

  assign in_ready  = (state_q == COLLECT);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || out_ready;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;

`ifdef BLOCK_PAD_EN
  assign done = (cnt_q == LAST_IDX) || in_last;
`else
  assign done = (cnt_q == LAST_IDX);
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    // Words past the counter are always zero in asm_q, which is what makes padding free.
    blk = asm_q;
    for (int k = 0; k < WORDS; k++) begin
      if (cnt_q == 2'(k)) blk[STATE_W-1-WORD_W*k -: WORD_W] = in_data;
    end

    if (drain) out_valid_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (done) begin
            cnt_d = '0;
            if (slot_free) begin
              out_d       = blk;
              out_valid_d = 1'b1;
              asm_d       = '0;
            end else begin
              asm_d   = blk;
              state_d = HOLD;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
            asm_d = blk;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_d       = asm_q;
          out_valid_d = 1'b1;
          asm_d       = '0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_block_assembler.sv
// Self-checking bench for block_assembler: directed scenarios plus randomized traffic against a queue model.
module tb_block_assembler;

`ifdef BLOCK_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid, in_ready, in_last;
  logic [127:0] out_data;
  logic         out_valid, out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clock = ~clock;

  block_assembler #(.WORD_W(32), .WORDS(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Model: completed blocks wait in a queue of depth 2 (output slot + held assembly).
  logic [127:0] exp_q[$];
  logic [31:0]  part[$];

  always @(posedge clock or negedge reset) begin
    bit acc, drn;
    logic [127:0] b;
    if (!reset) begin
      exp_q.delete();
      part.delete();
    end else begin
      acc = in_valid && (exp_q.size() < 2);
      drn = (exp_q.size() > 0) && out_ready;
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        part.push_back(in_data);
        if (part.size() == 4 || (PAD && in_last)) begin
          b = '0;
          for (int i = 0; i < part.size(); i++) b[127-32*i -: 32] = part[i];
          exp_q.push_back(b);
          part.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en && reset === 1'b1) begin
      chk("model_out_valid", out_valid, exp_q.size() > 0);
      chk("model_in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() > 0) chk("model_out_data", out_data, exp_q[0]);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int blocks;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // basic assembly
    cyc(1, 32'h00112233, 0, 1);
    cyc(1, 32'h44556677, 0, 1);
    cyc(1, 32'h8899AABB, 0, 1);
    chk("basic_not_yet", out_valid, 1'b0);
    cyc(1, 32'hCCDDEEFF, 0, 1);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_data", out_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    cyc(0, 0, 0, 1);
    chk("basic_drained", out_valid, 1'b0);

    // backpressure
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 32'hA0000000 + i, 0, 0);
      if (i == 4) chk("bp_first_valid", out_valid, 1'b1);
    end
    chk("bp_hold_in_ready", in_ready, 1'b0);
    chk("bp_first_stable", out_data, 128'hA0000001_A0000002_A0000003_A0000004);
    cyc(1, 32'hFFFFFFFF, 0, 0);
    chk("bp_ignored_in_ready", in_ready, 1'b0);
    chk("bp_ignored_data", out_data, 128'hA0000001_A0000002_A0000003_A0000004);
    cyc(0, 0, 0, 1);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_data", out_data, 128'hA0000005_A0000006_A0000007_A0000008);
    chk("bp_back_collect", in_ready, 1'b1);
    cyc(0, 0, 0, 1);
    chk("bp_empty", out_valid, 1'b0);

    // streaming
    blocks = 0;
    for (int i = 0; i < 12; i++) begin
      chk("stream_in_ready", in_ready, 1'b1);
      cyc(1, $urandom, 0, 1);
      if (out_valid) blocks++;
    end
    chk("stream_blocks", blocks, 3);
    cyc(0, 0, 0, 1);

    // reset mid-block with an occupied output slot
    for (int i = 0; i < 4; i++) cyc(1, 32'hB0000000 + i, 0, 0);
    cyc(1, 32'hC0000001, 0, 0);
    cyc(1, 32'hC0000002, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc(1, 32'hD0000001, 0, 1);
    cyc(1, 32'hD0000002, 0, 1);
    cyc(1, 32'hD0000003, 0, 1);
    cyc(1, 32'hD0000004, 0, 1);
    chk("midrst_new_valid", out_valid, 1'b1);
    chk("midrst_new_data", out_data, 128'hD0000001_D0000002_D0000003_D0000004);
    cyc(0, 0, 0, 1);

    // in_last handling
    cyc(1, 32'h01020304, 0, 1);
    cyc(1, 32'hDEADBEEF, 1, 1);
    if (PAD) begin
      chk("pad_valid", out_valid, 1'b1);
      chk("pad_data", out_data, 128'h01020304_DEADBEEF_00000000_00000000);
      cyc(1, 32'h0A0B0C0D, 0, 1);
      chk("pad_restart", out_valid, 1'b0);
      cyc(1, 32'h11111111, 0, 1);
      cyc(1, 32'h22222222, 0, 1);
      cyc(1, 32'h33333333, 0, 1);
      chk("pad_next_data", out_data, 128'h0A0B0C0D_11111111_22222222_33333333);
    end else begin
      chk("nopad_no_out", out_valid, 1'b0);
      cyc(1, 32'h11111111, 0, 1);
      chk("nopad_still_none", out_valid, 1'b0);
      cyc(1, 32'h22222222, 0, 1);
      chk("nopad_valid", out_valid, 1'b1);
      chk("nopad_data", out_data, 128'h01020304_DEADBEEF_11111111_22222222);
    end
    cyc(0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 6);
    end
    repeat (4) cyc(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
